// File: rtl/median_stream_pkg.sv
// median_pkg: shared rank encodings and depth limit for the streaming rank filter
package median_pkg;
    localparam logic [1:0] RANK_MEDIAN = 2'b00;
    localparam logic [1:0] RANK_MIN    = 2'b01;
    localparam logic [1:0] RANK_MAX    = 2'b10;
    localparam int         MAX_DEPTH   = 15;
endpackage

// File: rtl/median_stream_cmp_exch.sv
// cmp_exch: combinational compare-exchange, equal inputs pass through unchanged
module cmp_exch #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    assign hi = (a < b) ? b : a;
    assign lo = (a < b) ? a : b;
endmodule

// File: rtl/median_stream.sv
// median_stream: sliding-window rank filter (median/min/max) with an odd-even transposition sort pipeline
module median_stream
    import median_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       rank_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    if (DEPTH < 3 || DEPTH > MAX_DEPTH || DEPTH % 2 == 0) begin : g_bad_depth
        $error("median_stream: DEPTH must be odd and in 3..15");
    end

    logic [WIDTH-1:0] win_q [DEPTH];
    logic [WIDTH-1:0] win_d [DEPTH];
    logic [3:0]       fill_q, fill_d;
    logic [WIDTH-1:0] tok_q [DEPTH];
    logic [WIDTH-1:0] tok_d [DEPTH];
    logic             tok_vld_q, tok_vld_d;
    logic [1:0]       tok_rk_q, tok_rk_d;
    logic [WIDTH-1:0] st_q [DEPTH][DEPTH];
    logic [WIDTH-1:0] st_d [DEPTH][DEPTH];
    logic [WIDTH-1:0] stg_in [DEPTH][DEPTH];
    logic [WIDTH-1:0] stg_out [DEPTH][DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [1:0]       rk_q [DEPTH];
    logic [1:0]       rk_d [DEPTH];
    logic             adv, acc, tok;

    assign out_valid = vld_q[DEPTH-1];
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv & ~clear & ~rst;
    assign acc       = in_valid & in_ready;
    assign tok       = acc && (int'(fill_q) + 1 >= DEPTH);

    // Stage k sorts the registered lanes of stage k-1 (the token register feeds stage 0);
    // even stages pair (0,1),(2,3).. and odd stages pair (1,2),(3,4).., unpaired lanes pass through.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stg
        for (genvar i = 0; i < DEPTH; i++) begin : g_lane
            if (k == 0) begin : g_src_tok
                assign stg_in[k][i] = tok_q[i];
            end else begin : g_src_stg
                assign stg_in[k][i] = st_q[k-1][i];
            end
            if ((i % 2) == (k % 2) && i + 1 < DEPTH) begin : g_pair
                cmp_exch #(.WIDTH(WIDTH)) u_cx (
                    .a (stg_in[k][i]),
                    .b (stg_in[k][i+1]),
                    .hi(stg_out[k][i+1]),
                    .lo(stg_out[k][i])
                );
            end else if ((i % 2) == (k % 2) || i == 0) begin : g_pass
                assign stg_out[k][i] = stg_in[k][i];
            end
        end
    end

    // Next state: window shift and fill on accept, token capture when the window completes,
    // whole pipeline moves only on advance, clear drops fill and every valid bit.
    always_comb begin
        win_d     = win_q;
        fill_d    = fill_q;
        tok_d     = tok_q;
        tok_vld_d = tok_vld_q;
        tok_rk_d  = tok_rk_q;
        st_d      = st_q;
        vld_d     = vld_q;
        rk_d      = rk_q;
        if (acc) begin
            win_d[0] = in_data;
            for (int i = 1; i < DEPTH; i++) win_d[i] = win_q[i-1];
            fill_d = (int'(fill_q) == DEPTH) ? fill_q : fill_q + 4'd1;
        end
        if (tok) begin
            tok_d[0] = in_data;
            for (int i = 1; i < DEPTH; i++) tok_d[i] = win_q[i-1];
            tok_rk_d = rank_sel;
        end
        if (adv) begin
            tok_vld_d = tok;
            st_d      = stg_out;
            vld_d     = {vld_q[DEPTH-2:0], tok_vld_q};
            rk_d[0]   = tok_rk_q;
            for (int i = 1; i < DEPTH; i++) rk_d[i] = rk_q[i-1];
        end
        if (clear) begin
            fill_d    = '0;
            tok_vld_d = 1'b0;
            vld_d     = '0;
        end
    end

    // State registers; reset additionally zeroes all data so out_data reads 0 afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q    <= '0;
            tok_vld_q <= 1'b0;
            tok_rk_q  <= '0;
            vld_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
                tok_q[i] <= '0;
                rk_q[i]  <= '0;
                for (int j = 0; j < DEPTH; j++) st_q[i][j] <= '0;
            end
        end else begin
            win_q     <= win_d;
            fill_q    <= fill_d;
            tok_q     <= tok_d;
            tok_vld_q <= tok_vld_d;
            tok_rk_q  <= tok_rk_d;
            st_q      <= st_d;
            vld_q     <= vld_d;
            rk_q      <= rk_d;
        end
    end

    // Rank select from the final sorted lanes; lane 0 is the smallest value.
    always_comb begin
        out_data = (rk_q[DEPTH-1] == RANK_MIN) ? st_q[DEPTH-1][0] :
                   (rk_q[DEPTH-1] == RANK_MAX) ? st_q[DEPTH-1][DEPTH-1] :
                   st_q[DEPTH-1][(DEPTH-1)/2];
    end
endmodule

// File: tb/tb_median_stream.sv
// tb_median_stream: scoreboard bench for median_stream at DEPTH=3/WIDTH=8 and DEPTH=7/WIDTH=12
module tb_median_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    logic       rst3, clr3, iv3, ir3, or3, ov3;
    logic [7:0] id3, od3;
    logic [1:0] rs3;
    int         q3[$];

    median_stream #(.WIDTH(8), .DEPTH(3)) u3 (
        .clk(clk), .rst(rst3), .clear(clr3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .rank_sel(rs3), .out_valid(ov3), .out_ready(or3), .out_data(od3)
    );

    logic        rst7, clr7, iv7, ir7, or7, ov7;
    logic [11:0] id7, od7;
    logic [1:0]  rs7;
    int          q7[$];
    int          hist7[$];

    median_stream #(.WIDTH(12), .DEPTH(7)) u7 (
        .clk(clk), .rst(rst7), .clear(clr7), .in_valid(iv7), .in_ready(ir7), .in_data(id7),
        .rank_sel(rs7), .out_valid(ov7), .out_ready(or7), .out_data(od7)
    );

    always @(negedge clk) begin
        if (ov3 && or3) begin
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d3_unexpected_output: got %0d expected no output", od3);
            end else chk("d3_out", int'(od3), q3.pop_front());
        end
    end

    always @(negedge clk) begin
        if (ov7 && or7) begin
            if (q7.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d7_unexpected_output: got %0d expected no output", od7);
            end else chk("d7_out", int'(od7), q7.pop_front());
        end
    end

    function automatic int sel7(input int h[$], input int r);
        int a[7];
        int t;
        for (int i = 0; i < 7; i++) a[i] = h[i];
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 6 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j];
                    a[j] = a[j+1];
                    a[j+1] = t;
                end
        return (r == 1) ? a[0] : (r == 2) ? a[6] : a[3];
    endfunction

    always @(negedge clk) begin
        if (rst7 || clr7) hist7.delete();
        else if (iv7 && ir7) begin
            hist7.push_back(int'(id7));
            if (hist7.size() > 7) void'(hist7.pop_front());
            if (hist7.size() == 7) q7.push_back(sel7(hist7, int'(rs7)));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send3(input int v, input int r, input int e);
        int n = 0;
        iv3 = 1'b1;
        id3 = 8'(v);
        rs3 = 2'(r);
        if (e >= 0) q3.push_back(e);
        @(negedge clk);
        while (!ir3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ir3) begin
            checks++;
            failures++;
            $display("FAIL d3_accept_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        iv3 = 1'b0;
    endtask

    task automatic pulse_rst3();
        rst3 = 1'b1;
        cyc(2);
        rst3 = 1'b0;
    endtask

    task automatic count_valid3(input string nm, input int n);
        int seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (ov3) seen++;
        end
        chk(nm, seen, 0);
    endtask

    initial begin
        #800000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int lat, hv, acc7, ncyc, mode;
        rst3 = 1'b1; clr3 = 1'b0; iv3 = 1'b0; id3 = '0; rs3 = '0; or3 = 1'b1;
        rst7 = 1'b1; clr7 = 1'b0; iv7 = 1'b0; id7 = '0; rs7 = '0; or7 = 1'b1;
        cyc(3);
        rst3 = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", ov3, 0);
        chk("rst_out_data", od3, 0);
        chk("rst_in_ready", ir3, 1);
        @(posedge clk);
        #1;
        send3(5, 0, -1);
        send3(1, 0, -1);
        send3(9, 0, 5);
        lat = 0;
        while (!ov3 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency_cycles", lat, 3);
        send3(2, 0, 2);
        cyc(6);
        chk("t1_drain", q3.size(), 0);
        pulse_rst3();
        send3(4, 0, -1);
        send3(8, 0, -1);
        count_valid3("warmup_no_output", 50);
        @(posedge clk);
        #1;
        pulse_rst3();
        fork
            for (int i = 1; i <= 14; i++) send3(i * 10, 0, (i >= 3) ? (i - 1) * 10 : -1);
            begin
                int n = 0;
                while (!ov3 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1;
                or3 = 1'b0;
                @(negedge clk);
                hv = od3;
                chk("stall_first_held", hv, 30);
                repeat (10) begin
                    chk("stall_out_valid", ov3, 1);
                    chk("stall_data_hold", od3, hv);
                    chk("stall_in_ready", ir3, 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                or3 = 1'b1;
            end
        join
        cyc(8);
        chk("t3_no_loss", q3.size(), 0);
        pulse_rst3();
        send3(200, 0, -1);
        send3(7, 0, -1);
        send3(7, 1, 7);
        send3(200, 2, 200);
        send3(7, 0, 7);
        send3(9, 3, 9);
        send3(0, 1, 0);
        send3(250, 2, 250);
        cyc(8);
        chk("t4_drain", q3.size(), 0);
        pulse_rst3();
        send3(3, 0, -1);
        send3(6, 0, -1);
        send3(1, 0, 3);
        cyc(6);
        send3(50, 0, -1);
        send3(60, 0, -1);
        clr3 = 1'b1;
        iv3 = 1'b1;
        id3 = 8'd99;
        @(negedge clk);
        chk("clear_in_ready", ir3, 0);
        @(posedge clk);
        #1;
        clr3 = 1'b0;
        iv3 = 1'b0;
        @(negedge clk);
        chk("clear_out_valid", ov3, 0);
        count_valid3("clear_no_stale", 10);
        @(posedge clk);
        #1;
        send3(4, 0, -1);
        send3(8, 0, -1);
        send3(5, 0, 5);
        cyc(6);
        chk("t5_clear_drain", q3.size(), 0);
        send3(90, 0, -1);
        send3(80, 0, -1);
        rst3 = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", ir3, 0);
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", ov3, 0);
        chk("rst_mid_out_data", od3, 0);
        count_valid3("rst_mid_no_stale", 10);
        @(posedge clk);
        #1;
        send3(1, 0, -1);
        send3(2, 0, -1);
        send3(3, 0, 2);
        cyc(6);
        chk("t5_rst_drain", q3.size(), 0);
        rst7 = 1'b0;
        acc7 = 0;
        ncyc = 0;
        mode = 0;
        while (acc7 < 10000 && ncyc < 40000) begin
            if (ncyc % 40 == 0) mode = int'($urandom_range(3));
            iv7 = ($urandom_range(3) != 0);
            or7 = ($urandom_range(3) != 0);
            rs7 = 2'($urandom_range(3));
            id7 = (mode == 1) ? 12'd0 : (mode == 2) ? 12'hFFF : 12'($urandom);
            @(negedge clk);
            if (iv7 && ir7) acc7++;
            @(posedge clk);
            #1;
            ncyc++;
        end
        iv7 = 1'b0;
        or7 = 1'b1;
        cyc(20);
        chk("d7_accepted", acc7, 10000);
        chk("d7_drain", q7.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
